evb_bus_matrix: RTL
===================

# evb_bus_matrix

Parametrised EVB command router between the single master port (`mp_evb_*`) and NSLV peripheral slaves. It decodes a block field of the command address and forwards the request to exactly one slave. It runs a registered four-phase request/finish handshake on both sides and returns read data. Unmapped addresses and slaves that never answer complete with an error flag, so the master never hangs.

## Interface
- NSLV, 5, number of slave ports; slave i owns block index i+1; block 0 and blocks > NSLV are unmapped
- ADDR_W, 16, master address width
- DATA_W, 32, read/write data width
- BLK_LSB, 4, lowest address bit of the block field
- BLK_W, 4, block field width; requires NSLV < 2^BLK_W
- TIMEOUT, 255, cycles from slave request rise to forced error completion; must be ≥ 2
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- mp_evb_cmd_request  in  1  master request level
- mp_evb_cmd_addr  in  ADDR_W  command address; stable while request high
- mp_evb_cmd_wr  in  1  1 = write, 0 = read; stable while request high
- mp_evb_cmd_wr_data  in  DATA_W  write data; stable while request high
- mp_evb_cmd_finish  out  1  completion to master
- mp_evb_cmd_error  out  1  valid with finish: unmapped or timeout
- mp_evb_cmd_rd_data  out  DATA_W  read data, valid with finish
- slv_evb_cmd_request  out  NSLV  one-hot request vector
- slv_evb_cmd_addr  out  BLK_LSB  address offset bits [BLK_LSB-1:0], broadcast
- slv_evb_cmd_wr  out  1  broadcast direction
- slv_evb_cmd_wr_data  out  DATA_W  broadcast write data
- slv_evb_cmd_finish  in  NSLV  per-slave finish
- slv_evb_cmd_rd_data  in  NSLV*DATA_W  slave i at bits [i*DATA_W +: DATA_W]

## Operation
- Reset: all outputs 0, state IDLE, sel 0, counter 0.
- Decode: blk = addr[BLK_LSB+BLK_W-1:BLK_LSB]. The block is mapped when 1 ≤ blk ≤ NSLV, and then sel = blk-1. The decode is registered in IDLE and held for the whole transaction.
- Slave addr, wr and wr_data are registered copies captured in IDLE.
- FSM states: IDLE, WAIT, RESP, DRAIN.
- IDLE, request high:
  - Mapped: set slv_request[sel], clear counter, go to WAIT.
  - Unmapped: set mp_finish=1, mp_error=1, rd_data=0, go to RESP. No slave request is issued.
- WAIT:
  - slv_finish[sel] high: capture the slave's rd_data (0 on write), clear slv_request, set mp_finish=1 and mp_error=0, go to RESP.
  - Otherwise, if counter == TIMEOUT-1: clear slv_request, set mp_finish=1, mp_error=1, rd_data=0, go to RESP. Mark the transaction as timed out.
  - Otherwise increment the counter. Finish has priority over timeout in the same cycle.
  - Master drops request in WAIT (abort): clear slv_request, go to DRAIN, and never assert mp_finish. Abort has priority over finish and timeout.
  - Finish bits of non-selected slaves are ignored.
- RESP: hold finish, error and rd_data until the master drops request. Then clear finish and error (rd_data holds) and go to DRAIN.
- DRAIN:
  - Normal or aborted transaction: wait until slv_finish[sel] is low, then go to IDLE.
  - Unmapped or timed-out transaction: go to IDLE after one cycle.
  - A new master request is not sampled until IDLE.
- At most one slv_request bit is ever high.
- Counter width is clog2(TIMEOUT).

## Timing
- The master request is sampled at edge k in IDLE; slv_request rises after edge k.
- slv_finish is sampled at edge m; mp_finish and rd_data are valid after edge m (1-cycle response latency).
- The master request is seen low at edge r in RESP; mp_finish falls after edge r.
- Unmapped access: mp_finish rises 1 cycle after the request is sampled.
- Timeout: mp_finish rises exactly TIMEOUT cycles after slv_request rises.
- Minimum back-to-back spacing: after mp_finish falls there is 1 DRAIN cycle, then IDLE samples the next request.
- Asynchronous reset mid-transaction clears all outputs immediately and abandons the transaction.

## Test plan
- Read, slave 2, addr 0x0035, slave finishes 3 cycles after request with data 0xDEADBEEF:
  - slv_request=5'b00100 and slv_addr=5.
  - mp_finish rises 1 cycle after slave finish, with rd_data=0xDEADBEEF and error=0.
  - The handshake unwinds in order.
- Write to addr 0x0010 with wr_data 0x12345678: slave 0 sees wr=1 and wr_data=0x12345678; on completion rd_data=0 and error=0.
- Unmapped addr 0x0000 and 0x0060 (NSLV=5): no slv_request bit rises; mp_finish rises 1 cycle later with error=1 and rd_data=0.
- Silent slave with TIMEOUT=8: mp_finish and error rise exactly 8 cycles after slv_request rises, and slv_request is low at that point.
  - A subsequent request to slave 1 completes normally.
- Master abort: drop request 2 cycles into WAIT. slv_request falls and mp_finish never rises; the block returns to IDLE once the slave finish is low.
- Simultaneous events:
  - Slave finish arrives in the same cycle as the counter reaches TIMEOUT-1: the normal response wins (error=0).
  - Reset is asserted in WAIT: all outputs are 0 immediately.
  - After reset is released, a new request completes normally.

Source files
------------

// File: rtl/evb_bus_matrix.sv
// EVB command router: one master port fanned out to NSLV slaves by an
// address block decode, with registered request/finish handshakes on both
// sides, unmapped-address errors and a per-transaction response timeout.
module evb_bus_matrix #(
  parameter int NSLV    = 5,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int BLK_LSB = 4,
  parameter int BLK_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mp_evb_cmd_request,
  input  logic [ADDR_W-1:0]      mp_evb_cmd_addr,
  input  logic                   mp_evb_cmd_wr,
  input  logic [DATA_W-1:0]      mp_evb_cmd_wr_data,
  output logic                   mp_evb_cmd_finish,
  output logic                   mp_evb_cmd_error,
  output logic [DATA_W-1:0]      mp_evb_cmd_rd_data,
  output logic [NSLV-1:0]        slv_evb_cmd_request,
  output logic [BLK_LSB-1:0]     slv_evb_cmd_addr,
  output logic                   slv_evb_cmd_wr,
  output logic [DATA_W-1:0]      slv_evb_cmd_wr_data,
  input  logic [NSLV-1:0]        slv_evb_cmd_finish,
  input  logic [NSLV*DATA_W-1:0] slv_evb_cmd_rd_data
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Set for unmapped or timed-out transactions: no slave finish to wait out.
  logic               short_q, short_d;

  logic               fin_d, err_d, wr_d;
  logic [DATA_W-1:0]  rd_d, wr_data_d;
  logic [NSLV-1:0]    req_d;
  logic [BLK_LSB-1:0] addr_d;

  logic [BLK_W-1:0]   blk;
  logic               mapped;
  logic [SEL_W-1:0]   sel_dec;
  logic               sel_finish;
  logic [DATA_W-1:0]  sel_rd_data;

  // Block decode of the live master address and the selected slave's inputs.
  always_comb begin
    blk         = mp_evb_cmd_addr[BLK_LSB +: BLK_W];
    mapped      = (blk != '0) && (blk <= BLK_W'(NSLV));
    sel_dec     = SEL_W'(blk - BLK_W'(1));
    sel_finish  = slv_evb_cmd_finish[sel_q];
    sel_rd_data = slv_evb_cmd_rd_data[sel_q*DATA_W +: DATA_W];
  end

  // Next-state and next-output logic for both handshakes.
  always_comb begin
    // NOTE: every signal gets a hold-value default before the case so no path
    // leaves one unassigned; that is what keeps this block free of latches.
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    short_d   = short_q;
    fin_d     = mp_evb_cmd_finish;
    err_d     = mp_evb_cmd_error;
    rd_d      = mp_evb_cmd_rd_data;
    req_d     = slv_evb_cmd_request;
    addr_d    = slv_evb_cmd_addr;
    wr_d      = slv_evb_cmd_wr;
    wr_data_d = slv_evb_cmd_wr_data;

    unique case (state_q)
      IDLE: begin
        if (mp_evb_cmd_request) begin
          addr_d    = mp_evb_cmd_addr[BLK_LSB-1:0];
          wr_d      = mp_evb_cmd_wr;
          wr_data_d = mp_evb_cmd_wr_data;
          if (mapped) begin
            sel_d          = sel_dec;
            req_d          = '0;
            req_d[sel_dec] = 1'b1;
            cnt_d          = '0;
            short_d        = 1'b0;
            state_d        = WAIT;
          end else begin
            sel_d   = '0;
            fin_d   = 1'b1;
            err_d   = 1'b1;
            rd_d    = '0;
            short_d = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (!mp_evb_cmd_request) begin
          req_d   = '0;
          state_d = DRAIN;
        end else if (sel_finish) begin
          req_d   = '0;
          fin_d   = 1'b1;
          err_d   = 1'b0;
          rd_d    = slv_evb_cmd_wr ? '0 : sel_rd_data;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = '0;
          fin_d   = 1'b1;
          err_d   = 1'b1;
          rd_d    = '0;
          short_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (!mp_evb_cmd_request) begin
          fin_d   = 1'b0;
          err_d   = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (short_q || !sel_finish) begin
          short_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      sel_q               <= '0;
      cnt_q               <= '0;
      short_q             <= 1'b0;
      mp_evb_cmd_finish   <= 1'b0;
      mp_evb_cmd_error    <= 1'b0;
      mp_evb_cmd_rd_data  <= '0;
      slv_evb_cmd_request <= '0;
      slv_evb_cmd_addr    <= '0;
      slv_evb_cmd_wr      <= 1'b0;
      slv_evb_cmd_wr_data <= '0;
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values;
      // the combinational block above uses blocking assignments instead.
      state_q             <= state_d;
      sel_q               <= sel_d;
      cnt_q               <= cnt_d;
      short_q             <= short_d;
      mp_evb_cmd_finish   <= fin_d;
      mp_evb_cmd_error    <= err_d;
      mp_evb_cmd_rd_data  <= rd_d;
      slv_evb_cmd_request <= req_d;
      slv_evb_cmd_addr    <= addr_d;
      slv_evb_cmd_wr      <= wr_d;
      slv_evb_cmd_wr_data <= wr_data_d;
    end
  end

endmodule
